instr_encoder_loader: RTL and testbench

//  Encode-side counterpart of the main control decoder: packs instruction fields into 32-bit RV32I words.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/instr_encoder_loader_if.sv | 26 ++
 rtl/instr_field_encoder.sv | 42 ++++
 rtl/instr_encoder_loader.sv | 98 +++++++++
 tb/tb_instr_encoder_loader.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants and the instruction-class type used by the
// program loader and its field encoder.
package riscv_pkg;

   localparam int INSTR_WIDTH = 32;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      CLASS_LOAD   = 2'b00,
      CLASS_STORE  = 2'b01,
      CLASS_RTYPE  = 2'b10,
      CLASS_BRANCH = 2'b11
   } instr_class_t;

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Field-bundle handshake into the loader: the producer (master) offers one
// instruction's fields, the loader (slave) answers with in_ready.
interface instr_encoder_loader_if;
   import riscv_pkg::*;

   logic         in_valid;
   logic         in_ready;
   instr_class_t in_class;
   logic [4:0]   in_rd;
   logic [4:0]   in_rs1;
   logic [4:0]   in_rs2;
   logic [2:0]   in_funct3;
   logic [6:0]   in_funct7;
   logic [12:0]  in_imm;

   modport master (
      output in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
      output in_ready
   );

endinterface

// File: rtl/instr_field_encoder.sv
// Combinational packer: class + fields -> 32-bit RV32I word, plus a flag for
// immediates the chosen format cannot represent.
module instr_field_encoder
   import riscv_pkg::*;
(
   input  instr_class_t           cls,
   input  logic [4:0]             rd,
   input  logic [4:0]             rs1,
   input  logic [4:0]             rs2,
   input  logic [2:0]             funct3,
   input  logic [6:0]             funct7,
   input  logic [12:0]            imm,
   output logic [INSTR_WIDTH-1:0] word,
   output logic                   imm_err
);

   // NOTE: every output gets a default before the case so no path leaves a
   // value unassigned, which would otherwise infer a latch.
   always_comb begin
      word    = '0;
      imm_err = 1'b0;
      case (cls)
         CLASS_LOAD: begin
            word    = {imm[11:0], rs1, funct3, rd, OP_LOAD};
            imm_err = imm[12] ^ imm[11];
         end
         CLASS_STORE: begin
            word    = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
            imm_err = imm[12] ^ imm[11];
         end
         CLASS_RTYPE: begin
            word    = {funct7, rs2, rs1, funct3, rd, OP_RTYPE};
         end
         CLASS_BRANCH: begin
            // Branch offsets are in halfwords, so bit 0 must be zero.
            word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
            imm_err = imm[0];
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// Session-based program loader: accepts field bundles, encodes them and
// streams the words into instruction memory one cycle after acceptance.
module instr_encoder_loader
   import riscv_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   finish,
   instr_encoder_loader_if.slave  bus,
   output logic                   mem_we,
   output logic [ADDR_WIDTH-1:0]  mem_addr,
   output logic [INSTR_WIDTH-1:0] mem_wdata,
   output logic [ADDR_WIDTH:0]    count,
   output logic                   done,
   output logic                   err_imm
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_FULL = 2'd2;

   localparam logic [ADDR_WIDTH:0]   DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0]   ONE_CNT = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] ONE_PTR = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]             state;
   logic [ADDR_WIDTH-1:0]  ptr;
   logic [ADDR_WIDTH:0]    count_nxt;
   logic [INSTR_WIDTH-1:0] enc_word;
   logic                   enc_err;
   logic                   accept;

   instr_field_encoder u_enc (
      .cls     (bus.in_class),
      .rd      (bus.in_rd),
      .rs1     (bus.in_rs1),
      .rs2     (bus.in_rs2),
      .funct3  (bus.in_funct3),
      .funct7  (bus.in_funct7),
      .imm     (bus.in_imm),
      .word    (enc_word),
      .imm_err (enc_err)
   );

   // Ready drops combinationally on start/finish so a bundle can never be
   // accepted in the same cycle a session is opened or closed.
   assign bus.in_ready = (state == S_LOAD) && (count < DEPTH) && !start && !finish;
   assign accept       = bus.in_valid && bus.in_ready;
   assign count_nxt    = count + ONE_CNT;

   // NOTE: all state here uses non-blocking assignment so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         ptr       <= BASE_ADDR;
         count     <= '0;
         done      <= 1'b0;
         err_imm   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         // Write stage: a captured word always retires, even across start/finish.
         mem_we <= accept;
         if (accept) begin
            mem_addr  <= ptr;
            mem_wdata <= enc_word;
         end

         if (start) begin
            state   <= S_LOAD;
            ptr     <= BASE_ADDR;
            count   <= '0;
            done    <= 1'b0;
            err_imm <= 1'b0;
         end else if (state == S_LOAD) begin
            if (finish) begin
               state <= S_IDLE;
               done  <= 1'b1;
            end else if (accept) begin
               ptr     <= ptr + ONE_PTR;
               count   <= count_nxt;
               err_imm <= err_imm | enc_err;
               if (count_nxt == DEPTH) begin
                  state <= S_FULL;
                  done  <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench: directed spot values plus randomized traffic compared
// every cycle against an arithmetic model of the loader.
module tb_instr_encoder_loader;
   import riscv_pkg::*;

   localparam int AW    = 2;
   localparam int DEPTH = 1 << AW;
   localparam int BASE  = 0;

   logic          clk    = 1'b0;
   logic          rst    = 1'b1;
   logic          start  = 1'b0;
   logic          finish = 1'b0;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic [AW:0]   count;
   logic          done;
   logic          err_imm;

   int n_checks = 0;
   int n_errors = 0;

   instr_encoder_loader_if bus ();

   instr_encoder_loader #(
      .ADDR_WIDTH (AW),
      .BASE_ADDR  (AW'(BASE))
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .finish    (finish),
      .bus       (bus),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .count     (count),
      .done      (done),
      .err_imm   (err_imm)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference encoding built from integer field positions and signed ranges.
   function automatic logic [31:0] model_encode(input int cls, input int rd, input int rs1,
                                                input int rs2, input int f3, input int f7,
                                                input logic [12:0] imm, output bit bad);
      int v;
      int w;
      v   = int'($signed(imm));
      w   = 0;
      bad = 0;
      case (cls)
         0: begin
            w   = 'h03 | (rd << 7) | (f3 << 12) | (rs1 << 15) | ((v & 'hFFF) << 20);
            bad = (v < -2048) || (v > 2047);
         end
         1: begin
            w   = 'h23 | ((v & 31) << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20)
                  | (((v >> 5) & 127) << 25);
            bad = (v < -2048) || (v > 2047);
         end
         2: w = 'h33 | (rd << 7) | (f3 << 12) | (rs1 << 15) | (rs2 << 20) | (f7 << 25);
         default: begin
            w   = 'h63 | (((v >> 11) & 1) << 7) | (((v >> 1) & 15) << 8) | (f3 << 12)
                  | (rs1 << 15) | (rs2 << 20) | (((v >> 5) & 63) << 25) | (((v >> 12) & 1) << 31);
            bad = (v & 1) != 0;
         end
      endcase
      return 32'(w);
   endfunction

   bit          m_loading = 0;
   int          m_count   = 0;
   int          m_ptr     = 0;
   bit          m_done    = 0;
   bit          m_err     = 0;
   bit          m_we      = 0;
   int          m_addr    = 0;
   logic [31:0] m_wdata   = '0;

   function automatic bit exp_ready();
      return m_loading && (m_count < DEPTH) && !start && !finish;
   endfunction

   always @(posedge clk) begin : model_step
      bit          acc;
      bit          bad;
      logic [31:0] w;
      acc = bus.in_valid && exp_ready();
      w   = model_encode(int'(bus.in_class), int'(bus.in_rd), int'(bus.in_rs1), int'(bus.in_rs2),
                         int'(bus.in_funct3), int'(bus.in_funct7), bus.in_imm, bad);
      if (rst) begin
         m_loading <= 0;
         m_count   <= 0;
         m_ptr     <= BASE;
         m_done    <= 0;
         m_err     <= 0;
         m_we      <= 0;
         m_addr    <= 0;
         m_wdata   <= '0;
      end else begin
         m_we <= acc;
         if (acc) begin
            m_addr  <= m_ptr;
            m_wdata <= w;
         end
         if (start) begin
            m_loading <= 1;
            m_count   <= 0;
            m_ptr     <= BASE;
            m_err     <= 0;
            m_done    <= 0;
         end else if (m_loading) begin
            if (finish) begin
               m_loading <= 0;
               m_done    <= 1;
            end else if (acc) begin
               m_count <= m_count + 1;
               m_ptr   <= (m_ptr + 1) % DEPTH;
               if (bad) m_err <= 1;
               if (m_count + 1 == DEPTH) begin
                  m_loading <= 0;
                  m_done    <= 1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      check("in_ready",  32'(bus.in_ready), 32'(exp_ready()));
      check("mem_we",    32'(mem_we),       32'(m_we));
      check("mem_addr",  32'(mem_addr),     32'(m_addr));
      check("mem_wdata", mem_wdata,         m_wdata);
      check("count",     32'(count),        32'(m_count));
      check("done",      32'(done),         32'(m_done));
      check("err_imm",   32'(err_imm),      32'(m_err));
   end

   task automatic drive(input bit r, input bit s, input bit f, input bit v, input instr_class_t c,
                        input int rd, input int rs1, input int rs2, input int f3, input int f7,
                        input logic [12:0] imm);
      @(posedge clk);
      #1;
      rst           = r;
      start         = s;
      finish        = f;
      bus.in_valid  = v;
      bus.in_class  = c;
      bus.in_rd     = 5'(rd);
      bus.in_rs1    = 5'(rs1);
      bus.in_rs2    = 5'(rs2);
      bus.in_funct3 = 3'(f3);
      bus.in_funct7 = 7'(f7);
      bus.in_imm    = imm;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, CLASS_LOAD, 0, 0, 0, 0, 0, '0);
   endtask

   task automatic do_start();
      drive(0, 1, 0, 0, CLASS_LOAD, 0, 0, 0, 0, 0, '0);
   endtask

   task automatic send(input instr_class_t c, input int rd, input int rs1, input int rs2,
                       input int f3, input int f7, input logic [12:0] imm);
      drive(0, 0, 0, 1, c, rd, rs1, rs2, f3, f7, imm);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_class  = CLASS_LOAD;
      bus.in_rd     = '0;
      bus.in_rs1    = '0;
      bus.in_rs2    = '0;
      bus.in_funct3 = '0;
      bus.in_funct7 = '0;
      bus.in_imm    = '0;

      // Reset state
      drive(1, 0, 0, 0, CLASS_LOAD, 0, 0, 0, 0, 0, '0);
      @(negedge clk);
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ready", 32'(bus.in_ready), 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);

      // lw x5, 12(x2)
      do_start();
      send(CLASS_LOAD, 5, 2, 0, 3'b010, 0, 13'd12);
      idle();
      @(negedge clk);
      check("load_we", 32'(mem_we), 32'd1);
      check("load_addr", 32'(mem_addr), 32'd0);
      check("load_word", mem_wdata, 32'h00C12283);
      check("load_count", 32'(count), 32'd1);

      // beq x1, x2, -8
      send(CLASS_BRANCH, 0, 1, 2, 3'b000, 0, 13'h1FF8);
      idle();
      @(negedge clk);
      check("branch_word", mem_wdata, 32'hFE208CE3);
      check("branch_err", 32'(err_imm), 32'd0);
      check("branch_addr", 32'(mem_addr), 32'd1);

      // Out-of-range store offset sets the sticky error
      send(CLASS_STORE, 0, 3, 4, 3'b010, 0, 13'd2048);
      idle();
      @(negedge clk);
      check("store_err", 32'(err_imm), 32'd1);
      check("store_we", 32'(mem_we), 32'd1);

      send(CLASS_RTYPE, 7, 1, 2, 3'b000, 0, '0);
      idle();
      @(negedge clk);
      check("sticky_err", 32'(err_imm), 32'd1);
      check("full_count", 32'(count), 32'd4);
      check("full_done", 32'(done), 32'd1);
      check("full_ready", 32'(bus.in_ready), 32'd0);

      send(CLASS_LOAD, 1, 1, 0, 0, 0, 13'd4);
      idle();
      @(negedge clk);
      check("full_no_write", 32'(mem_we), 32'd0);

      do_start();
      idle();
      @(negedge clk);
      check("start_clears_err", 32'(err_imm), 32'd0);
      check("start_clears_done", 32'(done), 32'd0);
      check("start_ready", 32'(bus.in_ready), 32'd1);

      // Back-to-back fill
      for (int i = 0; i < 4; i++) send(CLASS_LOAD, i + 1, 2, 0, 3'b010, 0, 13'(4 * i));
      idle();
      @(negedge clk);
      check("b2b_last_addr", 32'(mem_addr), 32'd3);
      check("b2b_done", 32'(done), 32'd1);
      check("b2b_ready", 32'(bus.in_ready), 32'd0);

      // sub x1, x2, x3 then finish with a competing valid
      do_start();
      send(CLASS_RTYPE, 1, 2, 3, 3'b000, 7'b0100000, '0);
      idle();
      @(negedge clk);
      check("sub_word", mem_wdata, 32'h403100B3);
      drive(0, 0, 1, 1, CLASS_RTYPE, 4, 5, 6, 0, 0, '0);
      idle();
      @(negedge clk);
      check("finish_done", 32'(done), 32'd1);
      check("finish_no_write", 32'(mem_we), 32'd0);

      // Reset while a write is in flight
      do_start();
      for (int i = 0; i < 3; i++) send(CLASS_LOAD, 3, 4, 0, 0, 0, 13'(i));
      drive(1, 0, 0, 0, CLASS_LOAD, 0, 0, 0, 0, 0, '0);
      @(negedge clk);
      check("pre_rst_we", 32'(mem_we), 32'd1);
      idle();
      @(negedge clk);
      check("mid_rst_we", 32'(mem_we), 32'd0);
      check("mid_rst_addr", 32'(mem_addr), 32'd0);
      check("mid_rst_count", 32'(count), 32'd0);
      check("mid_rst_ready", 32'(bus.in_ready), 32'd0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         drive($urandom_range(0, 249) == 0, $urandom_range(0, 19) == 0,
               $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7,
               instr_class_t'($urandom_range(0, 3)),
               int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 127)), 13'($urandom));
      end
      idle();
      idle();
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
